board_writer: RTL and testbench
===============================

BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 Parameter BOARD_DIM, default 8, board side length in cells; legal range 2..15.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 The reset port SHALL be: reset  in  1  asynchronous, active-low; one clock, no other clock domains.
REQ-004 coord_valid  in  1  one-cycle strobe: coord holds a new move.
REQ-005 coord  in  8  move coordinate; [3:0] column, [7:4] row (same nibble split the button-entry stage produces).
REQ-006 coord_ready  out  1  high when a strobe will be captured.
REQ-007 rd_row  in  4, rd_col  in  4  renderer read address.
REQ-008 rd_cell  out  2  cell at rd_row/rd_col: 00 empty, 01 player A, 10 player B; 00 when the address is out of range.
REQ-009 turn  out  1  player to move: 0 = A, 1 = B.
REQ-010 move_count  out  8  number of accepted moves.
REQ-011 accept  out  1, reject  out  1  one-cycle result pulses.
REQ-012 reject_code  out  2  valid only with reject: 01 out of range, 10 occupied, 11 board full.
REQ-013 board_full  out  1  high when move_count == BOARD_DIM*BOARD_DIM.

Function
REQ-014 FSM states SHALL be IDLE, CHECK, WRITE, REJECT (+ CLEAR, see Configuration); coord_ready = 1 only in IDLE.
REQ-015 IDLE: coord_valid=1 -> capture coord into an internal register, go CHECK; strobes outside IDLE SHALL be ignored, not queued.
REQ-016 CHECK (one cycle): evaluate in priority order board full -> code 11; row or col >= BOARD_DIM -> code 01; target cell non-empty -> code 10; failing any check -> REJECT, else -> WRITE.
REQ-017 WRITE: cell <= turn ? 10 : 01; move_count += 1; turn toggles; accept = 1 for this cycle; -> IDLE.
REQ-018 REJECT: reject = 1 with reject_code for this cycle; board, turn and move_count unchanged; -> IDLE.
REQ-019 Latency: strobe sampled at edge N -> accept/reject high during cycle N+2 -> coord_ready high again from cycle N+3.
REQ-020 accept and reject SHALL never be high in the same cycle; reject_code = 00 whenever reject = 0.
REQ-021 rd_cell SHALL be combinational from board storage; a read of the cell being written in WRITE returns the old value, the new value from the next cycle.
REQ-022 move_count SHALL saturate at BOARD_DIM*BOARD_DIM; no wrap-around is possible because a full board rejects all moves.

Reset
REQ-023 reset = 0 SHALL immediately force: state IDLE, all cells 00, turn 0, move_count 0, accept/reject 0, reject_code 00, captured coord 0.
REQ-024 Reset asserted mid-move (CHECK/WRITE/REJECT) SHALL abort the move with no result pulse; deassertion returns to IDLE with coord_ready = 1 on the first edge.

Configuration
REQ-025 Macro BOARD_CLEAR_EN: when defined, add input clear (1, one-cycle strobe) and state CLEAR; when undefined, no clear port exists and the board is cleared only by reset.
REQ-026 With BOARD_CLEAR_EN: clear is sampled only in IDLE; clear wins over a simultaneous coord_valid (the coordinate is dropped); CLEAR writes 00 to one cell per cycle in index order 0..BOARD_DIM*BOARD_DIM-1, coord_ready = 0 throughout.
REQ-027 With BOARD_CLEAR_EN: after the last cell is cleared, turn <= 0 and move_count <= 0 on the same edge, then -> IDLE; clear sampled in a non-IDLE state is ignored.

Verification
REQ-028 Reset, then coord=8'h23 strobe -> accept at N+2, rd_row=2/rd_col=3 reads 01, turn=1, move_count=1.
REQ-029 Repeat coord=8'h23 -> reject at N+2 with code 10; rd_cell still 01, turn=1, move_count=1.
REQ-030 BOARD_DIM=8, coord=8'h29 -> reject code 01; coord=8'h90 -> reject code 01; no state change.
REQ-031 Fill all 64 cells with legal moves -> board_full=1, move_count=64; any further strobe -> reject code 11 (occupancy/range checks are not reported).
REQ-032 Strobe at N, pulse reset low during cycle N+1 -> no accept/reject pulse, board empty, coord_ready=1 after release.
REQ-033 BOARD_CLEAR_EN defined, 5 moves placed, clear and coord_valid in the same cycle -> coord_ready low for 64 cycles, then all cells 00, turn 0, move_count 0, no accept.

Source files
------------

// File: rtl/board_writer.sv
// Move-placement engine for a square game board: validates each strobed coordinate and writes the mover's mark.
// Optional macro BOARD_CLEAR_EN adds a clear strobe that wipes the board one cell per cycle.
module board_writer #(
    parameter int BOARD_DIM = 8
) (
    input  logic       clk,
    input  logic       reset,
`ifdef BOARD_CLEAR_EN
    input  logic       clear,
`endif
    input  logic       coord_valid,
    input  logic [7:0] coord,
    output logic       coord_ready,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output logic [1:0] rd_cell,
    output logic       turn,
    output logic [7:0] move_count,
    output logic       accept,
    output logic       reject,
    output logic [1:0] reject_code,
    output logic       board_full
);

    localparam int              CELLS   = BOARD_DIM * BOARD_DIM;
    localparam int              IDX_W   = $clog2(CELLS);
    localparam logic [4:0]      DIM_L   = 5'(BOARD_DIM);
    localparam logic [7:0]      CELLS_L = 8'(CELLS);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WRITE,
        REJECT,
        CLEAR
    } state_t;

    state_t             r_state;
    logic [7:0]         r_coord;
    logic [1:0]         r_board [CELLS];
    logic               r_turn;
    logic [7:0]         r_moveCount;
    logic               r_accept;
    logic               r_reject;
    logic [1:0]         r_rejectCode;
    logic               r_ready;
`ifdef BOARD_CLEAR_EN
    logic [IDX_W-1:0]   r_clearIdx;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
`endif

    logic [3:0]         w_capRow;
    logic [3:0]         w_capCol;
    logic               w_capInRange;
    logic [IDX_W-1:0]   w_capIdx;
    logic [1:0]         w_capCell;
    logic               w_rdInRange;
    logic [IDX_W-1:0]   w_rdIdx;
    logic               w_full;

    // Row-major flattening; only meaningful when both nibbles are below BOARD_DIM.
    function automatic logic [IDX_W-1:0] cellIndex(input logic [3:0] row, input logic [3:0] col);
        return IDX_W'(row) * IDX_W'(BOARD_DIM) + IDX_W'(col);
    endfunction

    assign w_capRow     = r_coord[7:4];
    assign w_capCol     = r_coord[3:0];
    assign w_capInRange = ({1'b0, w_capRow} < DIM_L) && ({1'b0, w_capCol} < DIM_L);
    assign w_capIdx     = cellIndex(w_capRow, w_capCol);
    assign w_capCell    = w_capInRange ? r_board[w_capIdx] : 2'b00;

    assign w_rdInRange  = ({1'b0, rd_row} < DIM_L) && ({1'b0, rd_col} < DIM_L);
    assign w_rdIdx      = cellIndex(rd_row, rd_col);
    assign rd_cell      = w_rdInRange ? r_board[w_rdIdx] : 2'b00;

    assign w_full       = (r_moveCount == CELLS_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_coord      <= 8'h00;
            for (int i = 0; i < CELLS; i++) begin
                r_board[i] <= 2'b00;
            end
            r_turn       <= 1'b0;
            r_moveCount  <= 8'h00;
            r_accept     <= 1'b0;
            r_reject     <= 1'b0;
            r_rejectCode <= 2'b00;
            r_ready      <= 1'b1;
`ifdef BOARD_CLEAR_EN
            r_clearIdx   <= '0;
`endif
        end else begin
            r_accept     <= 1'b0;
            r_reject     <= 1'b0;
            r_rejectCode <= 2'b00;
            case (r_state)
                IDLE: begin
`ifdef BOARD_CLEAR_EN
                    if (clear) begin
                        r_clearIdx <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= CLEAR;
                    end else
`endif
                    if (coord_valid) begin
                        r_coord <= coord;
                        r_ready <= 1'b0;
                        r_state <= CHECK;
                    end
                end
                // Result pulses are registered here so they are high exactly while in WRITE/REJECT.
                CHECK: begin
                    if (w_full) begin
                        r_reject     <= 1'b1;
                        r_rejectCode <= 2'b11;
                        r_state      <= REJECT;
                    end else if (!w_capInRange) begin
                        r_reject     <= 1'b1;
                        r_rejectCode <= 2'b01;
                        r_state      <= REJECT;
                    end else if (w_capCell != 2'b00) begin
                        r_reject     <= 1'b1;
                        r_rejectCode <= 2'b10;
                        r_state      <= REJECT;
                    end else begin
                        r_accept     <= 1'b1;
                        r_state      <= WRITE;
                    end
                end
                WRITE: begin
                    r_board[w_capIdx] <= r_turn ? 2'b10 : 2'b01;
                    if (!w_full) begin
                        r_moveCount <= r_moveCount + 8'd1;
                    end
                    r_turn  <= ~r_turn;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                REJECT: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
`ifdef BOARD_CLEAR_EN
                CLEAR: begin
                    r_board[r_clearIdx] <= 2'b00;
                    if (r_clearIdx == LAST_IDX) begin
                        r_turn      <= 1'b0;
                        r_moveCount <= 8'h00;
                        r_ready     <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_clearIdx  <= r_clearIdx + 1'b1;
                    end
                end
`endif
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign coord_ready = r_ready;
    assign turn        = r_turn;
    assign move_count  = r_moveCount;
    assign accept      = r_accept;
    assign reject      = r_reject;
    assign reject_code = r_rejectCode;
    assign board_full  = w_full;

endmodule

// File: tb/tb_board_writer.sv
// Randomized self-checking bench for board_writer (BOARD_DIM = 8) against a plain array model of the board.
// The clear scenario is compiled only when BOARD_CLEAR_EN is defined.
module tb_board_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       coord_valid;
    logic [7:0] coord;
    logic       coord_ready;
    logic [3:0] rd_row;
    logic [3:0] rd_col;
    logic [1:0] rd_cell;
    logic       turn;
    logic [7:0] move_count;
    logic       accept;
    logic       reject;
    logic [1:0] reject_code;
    logic       board_full;
`ifdef BOARD_CLEAR_EN
    logic       clear;
`endif

    int errors = 0;
    int checks = 0;

    logic [1:0] modelBoard [8][8];
    logic       modelTurn;
    int         modelCount;

    board_writer #(.BOARD_DIM(8)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef BOARD_CLEAR_EN
        .clear       (clear),
`endif
        .coord_valid (coord_valid),
        .coord       (coord),
        .coord_ready (coord_ready),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_cell     (rd_cell),
        .turn        (turn),
        .move_count  (move_count),
        .accept      (accept),
        .reject      (reject),
        .reject_code (reject_code),
        .board_full  (board_full)
    );

    always #5 clk = ~clk;

    // Result pulses must be exclusive and the code quiet without reject, every cycle.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if ((accept && reject) || (!reject && reject_code !== 2'b00)) begin
                errors++;
                $display("[TB] FAIL pulse_exclusive: accept=%b reject=%b code=%b required exclusive, code 00 without reject",
                         accept, reject, reject_code);
            end
        end
    end

    function automatic logic [1:0] modelCode(input int r, input int c);
        if (modelCount == 64) return 2'b11;
        if (r >= 8 || c >= 8) return 2'b01;
        if (modelBoard[r][c] != 2'b00) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] modelCell(input int r, input int c);
        if (r >= 8 || c >= 8) return 2'b00;
        return modelBoard[r][c];
    endfunction

    task automatic modelApply(input int r, input int c);
        modelBoard[r][c] = modelTurn ? 2'b10 : 2'b01;
        modelCount++;
        modelTurn = ~modelTurn;
    endtask

    task automatic modelReset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                modelBoard[r][c] = 2'b00;
        modelTurn  = 1'b0;
        modelCount = 0;
    endtask

    // Drives one strobe and records what the DUT showed in the CHECK, result and following IDLE cycles.
    task automatic driveMove(input logic [7:0] coordIn,
                             output logic readyMid, output logic earlyPulse,
                             output logic obsAccept, output logic obsReject,
                             output logic [1:0] obsCode, output logic [1:0] cellDuring,
                             output logic readyAfter, output logic latePulse);
        @(negedge clk);
        coord       = coordIn;
        coord_valid = 1'b1;
        rd_row      = coordIn[7:4];
        rd_col      = coordIn[3:0];
        @(negedge clk);
        coord_valid = 1'b0;
        readyMid    = coord_ready;
        earlyPulse  = accept | reject;
        @(negedge clk);
        obsAccept   = accept;
        obsReject   = reject;
        obsCode     = reject_code;
        cellDuring  = rd_cell;
        @(negedge clk);
        readyAfter  = coord_ready;
        latePulse   = accept | reject;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        coord_valid = 1'b0;
        coord       = 8'h00;
        rd_row      = 4'd0;
        rd_col      = 4'd0;
`ifdef BOARD_CLEAR_EN
        clear       = 1'b0;
`endif
        modelReset();
        repeat (3) @(negedge clk);
        checks++;
        if ({coord_ready, accept, reject, reject_code, turn, board_full} !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ready/acc/rej/code/turn/full=%b required 1000000",
                     {coord_ready, accept, reject, reject_code, turn, board_full});
        end
        checks++;
        if (move_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: move_count=%0d required 0", move_count);
        end
        for (int k = 0; k < 3; k++) begin
            rd_row = 4'($urandom_range(0, 7));
            rd_col = 4'($urandom_range(0, 7));
            #1;
            checks++;
            if (rd_cell !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_cell: cell(%0d,%0d)=%b required 00", rd_row, rd_col, rd_cell);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (coord_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: coord_ready=%b required 1", coord_ready);
        end
    endtask

    task automatic test_scripted();
        logic [7:0] seq [4];
        logic [1:0] expCode [4];
        logic rm, ep, ac, rj, ra, lp;
        logic [1:0] cd, code;
        seq     = '{8'h23, 8'h23, 8'h29, 8'h90};
        expCode = '{2'b00, 2'b10, 2'b01, 2'b01};
        for (int k = 0; k < 4; k++) begin
            driveMove(seq[k], rm, ep, ac, rj, code, cd, ra, lp);
            checks++;
            if ({rm, ep, ra, lp} !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL scripted_timing[%0d]: readyMid/early/readyAfter/late=%b required 0010",
                         k, {rm, ep, ra, lp});
            end
            checks++;
            if ({ac, rj, code} !== {(expCode[k] == 2'b00), (expCode[k] != 2'b00), expCode[k]}) begin
                errors++;
                $display("[TB] FAIL scripted_result[%0d]: acc/rej/code=%b%b%b required code %b",
                         k, ac, rj, code, expCode[k]);
            end
            if (k == 0) begin
                checks++;
                if (cd !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL scripted_old_read: cell during WRITE=%b required 00", cd);
                end
                modelApply(2, 3);
            end
            rd_row = 4'd2;
            rd_col = 4'd3;
            #1;
            checks++;
            if ({rd_cell, turn, move_count} !== {2'b01, 1'b1, 8'd1}) begin
                errors++;
                $display("[TB] FAIL scripted_state[%0d]: cell=%b turn=%b count=%0d required 01/1/1",
                         k, rd_cell, turn, move_count);
            end
        end
    endtask

    task automatic test_ignore_strobe();
        int pulses = 0;
        int prevCount;
        prevCount = modelCount;
        @(negedge clk);
        coord       = 8'h45;
        coord_valid = 1'b1;
        @(negedge clk);
        coord       = 8'h56;
        @(negedge clk);
        pulses += accept ? 1 : 0;
        @(negedge clk);
        coord_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pulses += (accept | reject) ? 1 : 0;
            @(negedge clk);
        end
        modelApply(4, 5);
        checks++;
        if (pulses !== 1 || move_count !== 8'(prevCount + 1)) begin
            errors++;
            $display("[TB] FAIL ignore_strobe: pulses=%0d count=%0d required 1 and %0d", pulses, move_count, prevCount + 1);
        end
        rd_row = 4'd5;
        rd_col = 4'd6;
        #1;
        checks++;
        if (rd_cell !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ignore_second_coord: cell(5,6)=%b required 00", rd_cell);
        end
        rd_row = 4'd4;
        rd_col = 4'd5;
        #1;
        checks++;
        if (rd_cell !== modelBoard[4][5]) begin
            errors++;
            $display("[TB] FAIL ignore_first_coord: cell(4,5)=%b required %b", rd_cell, modelBoard[4][5]);
        end
    endtask

    task automatic test_random_moves();
        logic rm, ep, ac, rj, ra, lp;
        logic [1:0] cd, code, expC, expOld;
        int r, c;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            c = $urandom_range(0, 9);
            expC   = modelCode(r, c);
            expOld = modelCell(r, c);
            driveMove({4'(r), 4'(c)}, rm, ep, ac, rj, code, cd, ra, lp);
            if (expC == 2'b00) modelApply(r, c);
            checks++;
            if ({rm, ep, ra, lp} !== 4'b0010 || {ac, rj, code} !== {(expC == 2'b00), (expC != 2'b00), expC}) begin
                errors++;
                $display("[TB] FAIL random_move(%0d,%0d): timing=%b acc/rej/code=%b%b%b required 0010 code %b",
                         r, c, {rm, ep, ra, lp}, ac, rj, code, expC);
            end
            checks++;
            if (cd !== expOld || rd_cell !== modelCell(r, c)) begin
                errors++;
                $display("[TB] FAIL random_read(%0d,%0d): during=%b after=%b required %b then %b",
                         r, c, cd, rd_cell, expOld, modelCell(r, c));
            end
            checks++;
            if (turn !== modelTurn || move_count !== 8'(modelCount)) begin
                errors++;
                $display("[TB] FAIL random_counters: turn=%b count=%0d required %b %0d",
                         turn, move_count, modelTurn, modelCount);
            end
        end
    endtask

    task automatic test_fill_board();
        logic rm, ep, ac, rj, ra, lp;
        logic [1:0] cd, code;
        logic [7:0] extra [4];
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (modelBoard[r][c] == 2'b00) begin
                    driveMove({4'(r), 4'(c)}, rm, ep, ac, rj, code, cd, ra, lp);
                    modelApply(r, c);
                    checks++;
                    if (ac !== 1'b1 || rj !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL fill_move(%0d,%0d): acc=%b rej=%b required 1 0", r, c, ac, rj);
                    end
                end
            end
        end
        checks++;
        if (board_full !== 1'b1 || move_count !== 8'd64 || turn !== modelTurn) begin
            errors++;
            $display("[TB] FAIL fill_full: full=%b count=%0d turn=%b required 1 64 %b",
                     board_full, move_count, turn, modelTurn);
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                rd_row = 4'(r);
                rd_col = 4'(c);
                #1;
                checks++;
                if (rd_cell !== modelBoard[r][c]) begin
                    errors++;
                    $display("[TB] FAIL fill_read(%0d,%0d): cell=%b required %b", r, c, rd_cell, modelBoard[r][c]);
                end
            end
        end
        extra = '{8'h23, 8'h99, 8'h00, 8'hF7};
        for (int k = 0; k < 4; k++) begin
            driveMove(extra[k], rm, ep, ac, rj, code, cd, ra, lp);
            checks++;
            if ({ac, rj, code} !== 4'b0111 || move_count !== 8'd64) begin
                errors++;
                $display("[TB] FAIL full_reject[%0d]: acc/rej/code=%b%b%b count=%0d required 0111 64",
                         k, ac, rj, code, move_count);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        int pulses = 0;
        logic rm, ep, ac, rj, ra, lp;
        logic [1:0] cd, code;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        coord       = 8'h11;
        coord_valid = 1'b1;
        rd_row      = 4'd1;
        rd_col      = 4'd1;
        @(negedge clk);
        coord_valid = 1'b0;
        reset       = 1'b0;
        #1;
        checks++;
        if (coord_ready !== 1'b1 || accept !== 1'b0 || reject !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_immediate: ready=%b acc=%b rej=%b required 1 0 0", coord_ready, accept, reject);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulses += (accept | reject) ? 1 : 0;
        end
        checks++;
        if (pulses !== 0 || coord_ready !== 1'b1 || rd_cell !== 2'b00 || move_count !== 8'd0 || turn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_after: pulses=%0d ready=%b cell=%b count=%0d turn=%b required 0 1 00 0 0",
                     pulses, coord_ready, rd_cell, move_count, turn);
        end
        driveMove(8'h11, rm, ep, ac, rj, code, cd, ra, lp);
        modelApply(1, 1);
        checks++;
        if (ac !== 1'b1 || rd_cell !== 2'b01 || move_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL midreset_resume: acc=%b cell=%b count=%0d required 1 01 1", ac, rd_cell, move_count);
        end
    endtask

`ifdef BOARD_CLEAR_EN
    task automatic test_clear();
        logic rm, ep, ac, rj, ra, lp;
        logic [1:0] cd, code;
        int lowCycles = 0;
        int accSeen = 0;
        int r, c;
        while (modelCount < 6) begin
            r = $urandom_range(0, 7);
            c = $urandom_range(0, 7);
            if (modelBoard[r][c] == 2'b00) begin
                driveMove({4'(r), 4'(c)}, rm, ep, ac, rj, code, cd, ra, lp);
                modelApply(r, c);
            end
        end
        @(negedge clk);
        clear       = 1'b1;
        coord_valid = 1'b1;
        coord       = 8'h77;
        @(negedge clk);
        clear       = 1'b0;
        coord_valid = 1'b0;
        while (coord_ready !== 1'b1 && lowCycles < 300) begin
            accSeen += accept ? 1 : 0;
            lowCycles++;
            @(negedge clk);
        end
        modelReset();
        checks++;
        if (lowCycles !== 64 || accSeen !== 0) begin
            errors++;
            $display("[TB] FAIL clear_duration: low cycles=%0d accepts=%0d required 64 0", lowCycles, accSeen);
        end
        checks++;
        if (turn !== 1'b0 || move_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL clear_counters: turn=%b count=%0d required 0 0", turn, move_count);
        end
        for (int rr = 0; rr < 8; rr++) begin
            for (int cc = 0; cc < 8; cc++) begin
                rd_row = 4'(rr);
                rd_col = 4'(cc);
                #1;
                checks++;
                if (rd_cell !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL clear_cell(%0d,%0d): cell=%b required 00", rr, cc, rd_cell);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scripted();
        test_ignore_strobe();
        test_random_moves();
        test_fill_board();
        test_reset_mid_move();
`ifdef BOARD_CLEAR_EN
        test_clear();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
